// File: rtl/sf_assoc_pkg.sv
// hnf_sf_pkg: shared types and constants for the sf_assoc snoop filter.
//   sf_op_e   : update opcodes (ALLOC_UNIQUE / ALLOC_SHARED / DEALLOC)
//   sf_fsm_e  : controller states (INIT / IDLE / EVICT)
//   SF_I/SF_SC/SF_UC/SF_UD : CHI cache-state encodings, `CHI_CACHE_STATE_W wide
`ifndef CHI_CACHE_STATE_W
`define CHI_CACHE_STATE_W 2
`endif

package hnf_sf_pkg;

  localparam int unsigned CST_W = `CHI_CACHE_STATE_W;

  typedef enum logic [1:0] {
    SF_ALLOC_UNIQUE = 2'd0,
    SF_ALLOC_SHARED = 2'd1,
    SF_DEALLOC      = 2'd2
  } sf_op_e;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_EVICT
  } sf_fsm_e;

  localparam logic [CST_W-1:0] SF_I  = CST_W'(0);
  localparam logic [CST_W-1:0] SF_SC = CST_W'(1);
  localparam logic [CST_W-1:0] SF_UC = CST_W'(2);
  localparam logic [CST_W-1:0] SF_UD = CST_W'(3);

endpackage

// File: rtl/sf_assoc_plru.sv
// sf_plru: tree pseudo-LRU helper for one set (purely combinational).
//   tree       : WAYS-1 tree bits, heap order (node n at index n-1, root = node 1)
//   touch_way  : way being accessed
//   victim     : way the tree currently points at
//   tree_next  : tree after touching touch_way (every node on the path points away)
// A tree bit of 0 steers the victim search to the left child, 1 to the right.
module sf_plru #(
  parameter int unsigned WAYS = 4
) (
  input  logic [WAYS-2:0]         tree,
  input  logic [$clog2(WAYS)-1:0] touch_way,
  output logic [$clog2(WAYS)-1:0] victim,
  output logic [WAYS-2:0]         tree_next
);

  localparam int unsigned LVL = $clog2(WAYS);

  // Victim and next-tree are kept in separate processes so a caller may derive
  // touch_way from victim without creating a combinational block cycle.
  always_comb begin
    logic [LVL:0] node;
    node    = '0;
    node[0] = 1'b1;
    for (int unsigned l = 0; l < LVL; l++) begin
      node = {node[LVL-1:0], tree[node[LVL-1:0] - 1'b1]};
    end
    victim = node[LVL-1:0];
  end

  always_comb begin
    logic [LVL:0]   node;
    logic [LVL-1:0] tw;
    logic           dir;
    tree_next = tree;
    node      = '0;
    node[0]   = 1'b1;
    tw        = touch_way;
    for (int unsigned l = 0; l < LVL; l++) begin
      dir = tw[LVL-1];
      tree_next[node[LVL-1:0] - 1'b1] = ~dir;
      node = {node[LVL-1:0], dir};
      tw   = tw << 1;
    end
  end

endmodule

// File: rtl/sf_assoc.sv
// sf_assoc: set-associative multi-RN snoop filter for the HN-F.
// Tracks tag, CHI state and RN-F presence vector per way; serves 1-cycle
// lookups, applies alloc/dealloc updates and issues back-invalidations when a
// full set must evict a tracked line.
// Ports:
//   clock, reset                    : clock, synchronous active-high reset
//   init_done                       : reset sweep finished
//   lkp_valid/ready/addr            : lookup request
//   rsp_valid/hit/state/vec         : lookup result, one cycle after accept
//   upd_valid/ready/op/addr/srcid/dirty : update request
//   evict_valid/ready/addr/vec      : back-invalidate request
// Optional: define SF_STATS_EN to add saturating stat_hit/stat_miss/stat_evict.
`ifndef CHI_CACHE_STATE_W
`define CHI_CACHE_STATE_W 2
`endif

module sf_assoc
  import hnf_sf_pkg::*;
#(
  parameter int unsigned ADDR_W = 48,
  parameter int unsigned OFF_W  = 6,
  parameter int unsigned SET_W  = 7,
  parameter int unsigned WAYS   = 4,
  parameter int unsigned NUM_RN = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  output logic                          init_done,
  input  logic                          lkp_valid,
  output logic                          lkp_ready,
  input  logic [ADDR_W-1:0]             lkp_addr,
  output logic                          rsp_valid,
  output logic                          rsp_hit,
  output logic [`CHI_CACHE_STATE_W-1:0] rsp_state,
  output logic [NUM_RN-1:0]             rsp_vec,
  input  logic                          upd_valid,
  output logic                          upd_ready,
  input  logic [1:0]                    upd_op,
  input  logic [ADDR_W-1:0]             upd_addr,
  input  logic [$clog2(NUM_RN)-1:0]     upd_srcid,
  input  logic                          upd_dirty,
  output logic                          evict_valid,
  input  logic                          evict_ready,
  output logic [ADDR_W-1:0]             evict_addr,
  output logic [NUM_RN-1:0]             evict_vec
`ifdef SF_STATS_EN
  ,
  output logic [31:0]                   stat_hit,
  output logic [31:0]                   stat_miss,
  output logic [31:0]                   stat_evict
`endif
);

  localparam int unsigned SET_NUM = 1 << SET_W;
  localparam int unsigned TAG_W   = ADDR_W - OFF_W - SET_W;
  localparam int unsigned WAY_W   = $clog2(WAYS);

  // Per-set storage
  logic [WAYS-1:0]   valid_mem [SET_NUM];
  logic [WAYS-2:0]   plru_mem  [SET_NUM];
  logic [TAG_W-1:0]  tag_mem   [SET_NUM][WAYS];
  logic [CST_W-1:0]  state_mem [SET_NUM][WAYS];
  logic [NUM_RN-1:0] vec_mem   [SET_NUM][WAYS];

  sf_fsm_e          state, state_nx;
  logic [SET_W-1:0] init_cnt;

  logic [SET_W-1:0] lkp_set, upd_set, plru_set;
  logic [TAG_W-1:0] lkp_tag, upd_tag;
  logic             lkp_fire, upd_fire;
  logic             lkp_hit, upd_hit, has_inv;
  logic [WAY_W-1:0] lkp_hit_way, upd_hit_way, inv_way, victim, wr_way, touch_way;
  logic [WAYS-2:0]  tree_next;
  logic [NUM_RN-1:0] src_oh, old_vec, wr_vec;
  logic [CST_W-1:0] wr_state;
  logic             wr_en, wr_clear, do_evict, touch_en;
  logic             unused_off;

  assign lkp_set = lkp_addr[OFF_W+SET_W-1:OFF_W];
  assign lkp_tag = lkp_addr[ADDR_W-1:OFF_W+SET_W];
  assign upd_set = upd_addr[OFF_W+SET_W-1:OFF_W];
  assign upd_tag = upd_addr[ADDR_W-1:OFF_W+SET_W];
  assign unused_off = ^{lkp_addr[OFF_W-1:0], upd_addr[OFF_W-1:0]};

  // Fire terms derive from the state register directly so the FSM output
  // process does not feed back into the update datapath.
  assign upd_fire = upd_valid && (state == ST_IDLE);
  assign lkp_fire = lkp_valid && !upd_valid && (state == ST_IDLE);

  // Lookup match
  always_comb begin
    lkp_hit     = 1'b0;
    lkp_hit_way = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (valid_mem[lkp_set][w] && tag_mem[lkp_set][w] == lkp_tag &&
          state_mem[lkp_set][w] != SF_I && !lkp_hit) begin
        lkp_hit     = 1'b1;
        lkp_hit_way = WAY_W'(w);
      end
    end
  end

  // Update match and lowest invalid way
  always_comb begin
    upd_hit     = 1'b0;
    upd_hit_way = '0;
    has_inv     = 1'b0;
    inv_way     = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (valid_mem[upd_set][w] && tag_mem[upd_set][w] == upd_tag &&
          state_mem[upd_set][w] != SF_I && !upd_hit) begin
        upd_hit     = 1'b1;
        upd_hit_way = WAY_W'(w);
      end
      if (!valid_mem[upd_set][w] && !has_inv) begin
        has_inv = 1'b1;
        inv_way = WAY_W'(w);
      end
    end
  end

  // Update datapath
  always_comb begin
    src_oh            = '0;
    src_oh[upd_srcid] = 1'b1;
    old_vec           = vec_mem[upd_set][upd_hit_way];
    wr_en             = 1'b0;
    wr_way            = upd_hit_way;
    wr_clear          = 1'b0;
    wr_vec            = old_vec;
    wr_state          = state_mem[upd_set][upd_hit_way];
    do_evict          = 1'b0;
    if (upd_fire) begin
      case (upd_op)
        SF_ALLOC_UNIQUE, SF_ALLOC_SHARED: begin
          wr_en = 1'b1;
          if (upd_op == SF_ALLOC_UNIQUE) begin
            wr_vec   = src_oh;
            wr_state = upd_dirty ? SF_UD : SF_UC;
          end else begin
            // A shared alloc on a unique line keeps the previous holder.
            wr_vec   = (upd_hit ? old_vec : '0) | src_oh;
            wr_state = SF_SC;
          end
          if (!upd_hit) begin
            if (has_inv) begin
              wr_way = inv_way;
            end else begin
              wr_way   = victim;
              do_evict = 1'b1;
            end
          end
        end
        SF_DEALLOC: begin
          if (upd_hit) begin
            wr_en  = 1'b1;
            wr_vec = old_vec & ~src_oh;
            if (wr_vec == '0) begin
              wr_clear = 1'b1;
              wr_state = SF_I;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Lookups and updates are never accepted together, so one PLRU port serves both.
  assign plru_set  = upd_fire ? upd_set : lkp_set;
  assign touch_way = upd_fire ? wr_way : lkp_hit_way;
  assign touch_en  = wr_en || (lkp_fire && lkp_hit);

  sf_plru #(.WAYS(WAYS)) u_plru (
    .tree      (plru_mem[plru_set]),
    .touch_way (touch_way),
    .victim    (victim),
    .tree_next (tree_next)
  );

  // Storage writes
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (state == ST_INIT) begin
        valid_mem[init_cnt] <= '0;
        plru_mem[init_cnt]  <= '0;
      end
      if (wr_en) begin
        valid_mem[upd_set][wr_way] <= ~wr_clear;
        tag_mem[upd_set][wr_way]   <= upd_tag;
        state_mem[upd_set][wr_way] <= wr_state;
        vec_mem[upd_set][wr_way]   <= wr_vec;
      end
      if (touch_en) begin
        plru_mem[plru_set] <= tree_next;
      end
    end
  end

  // FSM
  always_ff @(posedge clock) begin
    if (reset) state <= ST_INIT;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    init_done   = 1'b0;
    upd_ready   = 1'b0;
    lkp_ready   = 1'b0;
    evict_valid = 1'b0;
    case (state)
      ST_INIT: begin
        if (init_cnt == '1) state_nx = ST_IDLE;
      end
      ST_IDLE: begin
        init_done = 1'b1;
        upd_ready = 1'b1;
        lkp_ready = ~upd_valid;
        if (do_evict) state_nx = ST_EVICT;
      end
      ST_EVICT: begin
        init_done   = 1'b1;
        evict_valid = 1'b1;
        if (evict_ready) state_nx = ST_IDLE;
      end
      default: state_nx = ST_INIT;
    endcase
  end

  // Control registers
  always_ff @(posedge clock) begin
    if (reset) begin
      init_cnt   <= '0;
      rsp_valid  <= 1'b0;
      rsp_hit    <= 1'b0;
      rsp_state  <= SF_I;
      rsp_vec    <= '0;
      evict_addr <= '0;
      evict_vec  <= '0;
    end else begin
      if (state == ST_INIT) init_cnt <= init_cnt + 1'b1;
      rsp_valid <= lkp_fire;
      if (lkp_fire) begin
        rsp_hit   <= lkp_hit;
        rsp_state <= lkp_hit ? state_mem[lkp_set][lkp_hit_way] : SF_I;
        rsp_vec   <= lkp_hit ? vec_mem[lkp_set][lkp_hit_way] : '0;
      end
      if (do_evict) begin
        evict_addr <= {tag_mem[upd_set][victim], upd_set, {OFF_W{1'b0}}};
        evict_vec  <= vec_mem[upd_set][victim];
      end
    end
  end

`ifdef SF_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      stat_hit   <= '0;
      stat_miss  <= '0;
      stat_evict <= '0;
    end else begin
      if (lkp_fire && lkp_hit && stat_hit != '1)   stat_hit   <= stat_hit + 1'b1;
      if (lkp_fire && !lkp_hit && stat_miss != '1) stat_miss  <= stat_miss + 1'b1;
      if (evict_valid && evict_ready && stat_evict != '1)
        stat_evict <= stat_evict + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_sf_assoc.sv
// tb_sf_assoc: directed self-checking bench for sf_assoc.
`ifndef CHI_CACHE_STATE_W
`define CHI_CACHE_STATE_W 2
`endif

module tb_sf_assoc;
  import hnf_sf_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        init_done;
  logic        lkp_valid, lkp_ready;
  logic [47:0] lkp_addr;
  logic        rsp_valid, rsp_hit;
  logic [`CHI_CACHE_STATE_W-1:0] rsp_state;
  logic [3:0]  rsp_vec;
  logic        upd_valid, upd_ready;
  logic [1:0]  upd_op;
  logic [47:0] upd_addr;
  logic [1:0]  upd_srcid;
  logic        upd_dirty;
  logic        evict_valid, evict_ready;
  logic [47:0] evict_addr;
  logic [3:0]  evict_vec;
`ifdef SF_STATS_EN
  logic [31:0] stat_hit, stat_miss, stat_evict;
`endif

  int errors = 0;
  int checks = 0;

  sf_assoc #(.ADDR_W(48), .OFF_W(6), .SET_W(7), .WAYS(4), .NUM_RN(4)) dut (
    .clock(clock), .reset(reset), .init_done(init_done),
    .lkp_valid(lkp_valid), .lkp_ready(lkp_ready), .lkp_addr(lkp_addr),
    .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_state(rsp_state), .rsp_vec(rsp_vec),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_op(upd_op), .upd_addr(upd_addr),
    .upd_srcid(upd_srcid), .upd_dirty(upd_dirty),
    .evict_valid(evict_valid), .evict_ready(evict_ready),
    .evict_addr(evict_addr), .evict_vec(evict_vec)
`ifdef SF_STATS_EN
    , .stat_hit(stat_hit), .stat_miss(stat_miss), .stat_evict(stat_evict)
`endif
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic wait_init(input string tag);
    int n = 0;
    while (init_done !== 1'b1 && n < 300) begin
      if (n < 127) check({tag, "_lkp_rdy_lo"}, lkp_ready, 0);
      tick();
      n++;
    end
    check({tag, "_cycles"}, n, 128);
  endtask

  task automatic do_upd(input logic [1:0] op, input logic [47:0] addr,
                        input logic [1:0] src, input logic dirty, input string tag);
    upd_valid = 1'b1; upd_op = op; upd_addr = addr; upd_srcid = src; upd_dirty = dirty;
    #1 check({tag, "_upd_rdy"}, upd_ready, 1);
    tick();
    upd_valid = 1'b0;
  endtask

  task automatic do_lkp(input logic [47:0] addr, input logic hit,
                        input logic [1:0] st, input logic [3:0] vec, input string tag);
    lkp_valid = 1'b1; lkp_addr = addr;
    #1 check({tag, "_lkp_rdy"}, lkp_ready, 1);
    tick();
    lkp_valid = 1'b0;
    check({tag, "_rsp_valid"}, rsp_valid, 1);
    check({tag, "_hit"}, rsp_hit, hit);
    check({tag, "_state"}, rsp_state, st);
    check({tag, "_vec"}, rsp_vec, vec);
  endtask

  initial begin
    reset = 1'b1; lkp_valid = 1'b0; lkp_addr = '0; upd_valid = 1'b0; upd_op = '0;
    upd_addr = '0; upd_srcid = '0; upd_dirty = 1'b0; evict_ready = 1'b0;

    // Reset values
    tick(); tick(); tick();
    check("rst_init_done", init_done, 0);
    check("rst_lkp_ready", lkp_ready, 0);
    check("rst_upd_ready", upd_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_evict_valid", evict_valid, 0);
    check("rst_evict_addr", evict_addr, 0);
    check("rst_rsp_vec", rsp_vec, 0);

    reset = 1'b0;
    wait_init("init");

    // Unique dirty alloc, then lookup
    do_upd(SF_ALLOC_UNIQUE, 48'h1000, 2'd2, 1'b1, "u1");
    do_lkp(48'h1000, 1'b1, SF_UD, 4'b0100, "l1");
    tick();
    check("rsp_pulse", rsp_valid, 0);

    // Shared allocs downgrade to SC and accumulate
    do_upd(SF_ALLOC_SHARED, 48'h1000, 2'd0, 1'b0, "s0");
    do_upd(SF_ALLOC_SHARED, 48'h1000, 2'd3, 1'b0, "s3");
    do_lkp(48'h1000, 1'b1, SF_SC, 4'b1101, "l2");

    // Deallocs down to empty
    do_upd(SF_DEALLOC, 48'h1000, 2'd0, 1'b0, "d0");
    do_lkp(48'h1000, 1'b1, SF_SC, 4'b1100, "l3");
    do_upd(SF_DEALLOC, 48'h1000, 2'd2, 1'b0, "d2");
    do_upd(SF_DEALLOC, 48'h1000, 2'd3, 1'b0, "d3");
    do_lkp(48'h1000, 1'b0, SF_I, 4'b0000, "l4");

    // Update and lookup in the same cycle: update wins
    upd_valid = 1'b1; upd_op = SF_ALLOC_SHARED; upd_addr = 48'h1000; upd_srcid = 2'd1;
    lkp_valid = 1'b1; lkp_addr = 48'h1000;
    #1 check("both_lkp_rdy", lkp_ready, 0);
    check("both_upd_rdy", upd_ready, 1);
    tick();
    upd_valid = 1'b0;
    check("both_no_rsp", rsp_valid, 0);
    #1 check("both_lkp_rdy2", lkp_ready, 1);
    tick();
    lkp_valid = 1'b0;
    check("both_rsp_valid", rsp_valid, 1);
    check("both_hit", rsp_hit, 1);
    check("both_state", rsp_state, SF_SC);
    check("both_vec", rsp_vec, 4'b0010);

    // Fill set 0 with tags 1..4, fifth evicts tag 1 (PLRU points at way 0)
    for (int k = 1; k <= 4; k++) begin
      do_upd(SF_ALLOC_UNIQUE, 48'(k) << 13, 2'(k - 1), 1'b0, "fill");
      check("fill_no_evict", evict_valid, 0);
    end
    do_upd(SF_ALLOC_UNIQUE, 48'(5) << 13, 2'd0, 1'b0, "fill5");
    check("ev_valid", evict_valid, 1);
    check("ev_addr", evict_addr, 48'h2000);
    check("ev_vec", evict_vec, 4'b0001);
    lkp_valid = 1'b1; lkp_addr = 48'h2000;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("ev_hold_valid", evict_valid, 1);
      check("ev_hold_lkp_rdy", lkp_ready, 0);
      check("ev_hold_upd_rdy", upd_ready, 0);
      check("ev_hold_rsp", rsp_valid, 0);
    end
    lkp_valid = 1'b0;
    evict_ready = 1'b1;
    #1 check("ev_hs_valid", evict_valid, 1);
    tick();
    evict_ready = 1'b0;
    check("ev_done_valid", evict_valid, 0);
    check("ev_done_upd_rdy", upd_ready, 1);
    do_lkp(48'(1) << 13, 1'b0, SF_I, 4'b0000, "ev_t1");
    do_lkp(48'(5) << 13, 1'b1, SF_UC, 4'b0001, "ev_t5");
    do_lkp(48'(2) << 13, 1'b1, SF_UC, 4'b0010, "ev_t2");

    // Shared alloc on a unique line keeps previous holder
    do_upd(SF_ALLOC_SHARED, 48'(5) << 13, 2'd1, 1'b0, "dg");
    do_lkp(48'(5) << 13, 1'b1, SF_SC, 4'b0011, "dg_l");

    // Reset while in EVICT
    do_upd(SF_ALLOC_UNIQUE, 48'(6) << 13, 2'd3, 1'b0, "t6");
    check("t6_evict", evict_valid, 1);
    reset = 1'b1;
    tick();
    check("rst_ev_valid", evict_valid, 0);
    check("rst_ev_init_done", init_done, 0);
    tick();
    reset = 1'b0;
    wait_init("reinit");
    check("reinit_ev_valid", evict_valid, 0);
    do_lkp(48'(5) << 13, 1'b0, SF_I, 4'b0000, "reinit_t5");
    do_lkp(48'h1000, 1'b0, SF_I, 4'b0000, "reinit_1000");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
